// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths and FSM state encoding for the fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;
    localparam int INS_W  = 32;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;
endpackage

`default_nettype wire

// File: rtl/fetch_buf.sv
// ============================================================================
// Module      : fetch_buf
// Description : Two-entry FIFO holding fetched words and their tags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buf #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = pop_i && (count_q != 2'd0);
    assign w_push = push_i && ((count_q != 2'd2) || w_pop);

    // Flush wins: a coincident pop has already been consumed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
// Module      : fetch_controller
// Description : Instruction fetch sequencer with redirect, halt and a 2-deep
//               decode buffer. Define FETCH_PERF_EN for the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_controller
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4096,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INS_W-1:0]  mem_ins,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
);
    localparam int PC_W = $clog2(DEPTH);

    fetch_state_e             state_q, state_d;
    logic [PC_W-1:0]          fetch_pc_q, fetch_pc_d;
    logic                     inflight_q;
    logic [ADDR_W-1:0]        tag_q;

    logic [1:0]               w_count;
    logic [2:0]               w_occ;
    logic                     w_pop;
    logic                     w_issue;
    logic                     w_push;
    logic [INS_W+ADDR_W-1:0]  w_head;

    assign ins_valid = (w_count != 2'd0);
    assign w_pop     = ins_valid && ins_ready;
    // Occupancy as it will stand after this edge's pop, before any push.
    assign w_occ     = {1'b0, w_count} + {2'b0, inflight_q} - {2'b0, w_pop};
    assign w_issue   = (state_q == ST_RUN) && !halt && !redirect_valid && (w_occ < 3'd2);
    assign w_push    = inflight_q && !redirect_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (halt)  state_d = ST_HALTED;
            ST_HALTED: if (!halt) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = PC_W'(32'(redirect_pc) % 32'(DEPTH));
        end else if (w_issue) begin
            fetch_pc_d = (fetch_pc_q == PC_W'(DEPTH - 1)) ? '0 : fetch_pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= PC_W'(RESET_PC);
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= w_issue;
            if (w_issue) begin
                tag_q <= ADDR_W'(fetch_pc_q);
            end
        end
    end

    fetch_buf #(
        .W (INS_W + ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .din_i   ({tag_q, mem_ins}),
        .dout_o  (w_head),
        .count_o (w_count)
    );

    assign mem_addr = ADDR_W'(fetch_pc_q);
    assign ins_out  = w_head[INS_W-1:0];
    assign ins_pc   = w_head[INS_W +: ADDR_W];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (w_pop) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if ((state_q == ST_RUN) && !w_issue) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// ============================================================================
// Module      : tb_fetch_controller
// Description : Self-checking bench; stream-order reference model plus
//               directed latency, hold, redirect, halt and counter scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_controller;
    localparam int          DEPTH    = 4096;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr;
    logic [31:0] mem_ins;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt = 1'b0;
    logic [31:0] ins_out;
    logic [15:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready = 1'b1;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_xfer  = 0;
    logic [15:0] exp_pc  = RESET_PC;

    fetch_controller #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_ins        (mem_ins),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .ins_out        (ins_out),
        .ins_pc         (ins_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word i holds i*3.
    always @(posedge clk) mem_ins <= 32'(mem_addr) * 32'd3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: score any transfer at the coming edge, apply redirects to
    // the expected stream, then verify hold behaviour on the far side.
    task automatic tick();
        logic        hold;
        logic [15:0] hpc;
        logic [31:0] hins;
        hold = ins_valid && !ins_ready && !redirect_valid;
        hpc  = ins_pc;
        hins = ins_out;
        if (ins_valid && ins_ready) begin
            chk("xfer_pc", 32'(ins_pc), 32'(exp_pc));
            chk("xfer_ins", ins_out, 32'(exp_pc) * 32'd3);
            exp_pc = 16'((32'(exp_pc) + 32'd1) % DEPTH);
            n_xfer++;
        end
        if (redirect_valid) exp_pc = 16'(32'(redirect_pc) % DEPTH);
        @(negedge clk);
        if (hold) begin
            chk("hold_valid", 32'(ins_valid), 32'd1);
            chk("hold_pc", 32'(ins_pc), 32'(hpc));
            chk("hold_ins", ins_out, hins);
        end
    endtask

    task automatic reset_and_start();
        rst_n          = 1'b0;
        ins_ready      = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'(RESET_PC));
        chk("rst_ins", ins_out, 32'd0);
        chk("rst_pc", 32'(ins_pc), 32'd0);
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        exp_pc = RESET_PC;
        n_xfer = 0;
        rst_n  = 1'b1;
        tick(); chk("boot_idle1", 32'(ins_valid), 32'd0);
        tick(); chk("boot_idle2", 32'(ins_valid), 32'd0);
        tick();
        chk("first_valid", 32'(ins_valid), 32'd1);
        chk("first_pc", 32'(ins_pc), 32'(RESET_PC));
        chk("first_ins", ins_out, 32'(RESET_PC) * 32'd3);
    endtask

    initial begin
        logic [15:0] frozen;
        int          n0;

        // Reset release and full-rate streaming.
        reset_and_start();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("tput_valid", 32'(ins_valid), 32'd1);
        end

        // Backpressure: buffer fills, fetch address freezes, stream resumes.
        ins_ready = 1'b0;
        tick();
        frozen = mem_addr;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_addr", 32'(mem_addr), 32'(frozen));
        end
        ins_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("bp_tput", 32'(ins_valid), 32'd1);
        end

        // Redirect with two entries buffered.
        ins_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        ins_ready      = 1'b1;
        chk("redir_flush", 32'(ins_valid), 32'd0);
        tick(); chk("redir_gap", 32'(ins_valid), 32'd0);
        tick();
        chk("redir_valid", 32'(ins_valid), 32'd1);
        chk("redir_pc", 32'(ins_pc), 32'h20);
        chk("redir_ins", ins_out, 32'd96);

        // Redirect to the last word: wraps to zero.
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0FFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("wrap_first", 32'(ins_pc), 32'h0FFF);
        tick();
        chk("wrap_valid", 32'(ins_valid), 32'd1);
        chk("wrap_pc", 32'(ins_pc), 32'h0000);

        // Halt for four cycles mid-stream.
        repeat (3) tick();
        halt = 1'b1;
        tick();
        frozen = mem_addr;
        n0     = n_xfer;
        repeat (3) tick();
        chk("halt_addr", 32'(mem_addr), 32'(frozen));
        chk("halt_le1", 32'((n_xfer - n0) <= 1), 32'd1);
        halt = 1'b0;
        repeat (8) tick();
        chk("resume_valid", 32'(ins_valid), 32'd1);

        // Randomized traffic against the stream model.
        for (int k = 0; k < 400; k++) begin
            ins_ready      = ($urandom_range(0, 99) < 70);
            halt           = halt ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 4);
            redirect_valid = ($urandom_range(0, 99) < 5);
            redirect_pc    = 16'($urandom);
            tick();
        end
        redirect_valid = 1'b0;
        halt           = 1'b0;
        ins_ready      = 1'b1;
        for (int k = 0; k < 20 && !ins_valid; k++) tick();
        chk("live_valid", 32'(ins_valid), 32'd1);
`ifdef FETCH_PERF_EN
        chk("perf_rand_fetch", perf_fetch_cnt, 32'(n_xfer));
`endif

        // Mid-operation reset, then 10 transfers with 5 backpressure cycles.
        reset_and_start();
        for (int k = 0; k < 40 && n_xfer < 5; k++) tick();
        chk("xfer5", 32'(n_xfer), 32'd5);
        ins_ready = 1'b0;
        repeat (5) tick();
        ins_ready = 1'b1;
        for (int k = 0; k < 40 && n_xfer < 10; k++) tick();
        chk("xfer10", 32'(n_xfer), 32'd10);
        ins_ready = 1'b0;
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 32'd10);
        chk("perf_stall_ge5", 32'(perf_stall_cnt >= 32'd5), 32'd1);
`else
        chk("perf_fetch_off", perf_fetch_cnt, 32'd0);
        chk("perf_stall_off", perf_stall_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 4096: instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000: first word address fetched after reset.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port mem_addr, output, 16: word address to the instruction memory; the memory returns data one posedge later.
REQ-006 SHALL have port mem_ins, input, 32: instruction word from the memory for the address sampled at the previous posedge.
REQ-007 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 16): branch/jump target request.
REQ-008 SHALL have port halt, input, 1: level request to stop issuing fetches.
REQ-009 SHALL have ports ins_out (output, 32), ins_pc (output, 16), ins_valid (output, 1) and ins_ready (input, 1): decode-side valid/ready handshake.
REQ-010 SHALL have ports perf_fetch_cnt (output, 32) and perf_stall_cnt (output, 32): performance counters.

Function
REQ-011 SHALL implement FSM states BOOT, RUN and HALTED: BOOT->RUN at the first posedge after reset release; RUN->HALTED on halt=1; HALTED->RUN on halt=0.
REQ-012 SHALL drive mem_addr from a registered fetch_pc, zero-extended from log2(DEPTH) bits.
REQ-013 SHALL issue a fetch at a posedge only in RUN with halt=0, redirect_valid=0 and (buffered + in-flight - popped-this-edge) < 2.
REQ-014 SHALL, on issue, record one in-flight tag equal to fetch_pc and advance fetch_pc by 1 modulo DEPTH, so that DEPTH-1 wraps to 0.
REQ-015 SHALL write mem_ins with its tag into a 2-entry FIFO at the posedge after issue; ins_out and ins_pc SHALL be the FIFO head, and ins_valid SHALL mean the FIFO is non-empty.
REQ-016 SHALL hold ins_out and ins_pc stable while ins_valid=1 and ins_ready=0; a transfer occurs only on a posedge with ins_valid and ins_ready both high.
REQ-017 SHALL sustain one instruction per cycle at steady state with ins_ready=1.
REQ-018 SHALL, on a redirect_valid posedge, complete any transfer handshaking at that edge, then discard the remaining FIFO entries and the in-flight response, and load fetch_pc with redirect_pc modulo DEPTH.
REQ-019 SHALL present the redirect target as ins_pc with ins_valid=1 after the second posedge following the redirect edge.
REQ-020 SHALL give redirect priority over issue; in HALTED, a redirect SHALL update fetch_pc but issue nothing.
REQ-021 SHALL, on entering HALTED, still deliver the in-flight response into the FIFO.

Reset
REQ-022 SHALL, while rst_n=0, force: state=BOOT, fetch_pc=RESET_PC, mem_addr=RESET_PC, FIFO empty, no fetch in flight, ins_valid=0, ins_out=0, ins_pc=0, and both counters 0.
REQ-023 SHALL, when reset asserts mid-operation, drop all buffered and in-flight words; the first ins_valid after release is ins_pc=RESET_PC, after the third posedge.

Configuration
REQ-024 SHALL, with FETCH_PERF_EN defined, increment perf_fetch_cnt on each transfer and perf_stall_cnt on each posedge in RUN where issue is blocked; both counters SHALL wrap at 2^32.
REQ-025 SHALL, without FETCH_PERF_EN, tie both counter outputs to 0 and infer no counter flops.

Structure
REQ-026 SHALL place INS_W=32, ADDR_W=16 and the FSM state enum in shared package fetch_pkg.
REQ-027 SHALL implement the 2-entry FIFO as sub-module fetch_buf, with push, pop, flush, data+tag, and count.

Verification
REQ-028 SHALL cover reset release with ins_ready=1 and memory word i = i*3: first ins_valid after the third posedge with ins_pc=0, ins_out=0, then ins_pc 1, 2, 3 on consecutive cycles.
REQ-029 SHALL cover ins_ready=0 for 5 cycles: 2 entries buffered, mem_addr frozen, ins_out stable; after release ins_pc continues with no gap or duplicate.
REQ-030 SHALL cover a redirect to 16'h0020 with 2 entries buffered: both dropped; ins_pc=16'h0020 with ins_out=96 after the second posedge.
REQ-031 SHALL cover a redirect to 16'h0FFF: ins_pc sequence 16'h0FFF then 16'h0000.
REQ-032 SHALL cover halt=1 for 4 cycles mid-stream: at most one further word delivered and no issue; after halt=0, fetch resumes at the next sequential pc.
REQ-033 SHALL cover FETCH_PERF_EN defined with 10 transfers and 5 backpressure cycles: perf_fetch_cnt=10, perf_stall_cnt>=5; with the macro undefined, both counters read 0.
